qmac_pipe: RTL and testbench
============================

Name: qmac_pipe

Overview:
Pipelined, parametrised signed multiply-accumulate unit. It is the sequential successor to the combinational qmult.
- Streams operand pairs with a valid qualifier.
- Accumulates products over a group framed by first/last markers.
- Emits the full-width accumulator plus a rounded, requantised, saturated DWIDTH result.
- Forms the PE datapath core of the systolic array in qsim_rtl.

Parameters:
DWIDTH, 8, operand width and requantised output width (signed two's complement)
AWIDTH, 24, accumulator width; must be >= 2*DWIDTH
SWIDTH, 5, width of the requantisation shift amount

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous, active-high reset
i_valid  in  1  operand pair valid this cycle
i_first  in  1  qualified by i_valid; product starts a new group (load, not add)
i_last  in  1  qualified by i_valid; product closes the group; result emitted
i_multiplicand  in  DWIDTH  signed operand A
i_multiplier  in  DWIDTH  signed operand B
i_shift  in  SWIDTH  arithmetic right-shift for requantisation; sampled with i_valid&i_last
o_valid  out  1  one-cycle pulse; group result valid
o_acc  out  AWIDTH  signed accumulator value of the closed group
o_q  out  DWIDTH  rounded, shifted, saturated result
o_ovf  out  1  accumulator saturated at some point in this group
o_qsat  out  1  o_q was clipped to the DWIDTH range

Behaviour:
- Reset (synchronous, i_rst=1 at clock edge):
  - All pipeline valids cleared; accumulator and sticky overflow cleared to 0.
  - o_valid=0, o_acc=0, o_q=0, o_ovf=0, o_qsat=0.
  - Reset mid-group discards the group; no output is produced for it.
- Pipeline: 4 register stages, no stall and no ready; accepts one pair every cycle.
  - S1: register operands, first, last, shift, and valid.
  - S2: register the signed 2*DWIDTH product (qmult instance). The product is exact; -2^(DWIDTH-1) squared fits.
  - S3: accumulate; product is sign-extended to AWIDTH.
    - If first: acc=product and ovf=0.
    - Else: acc=sat(acc+product).
    - Sum computed at AWIDTH+1 bits. On overflow, clamp to 2^(AWIDTH-1)-1 or -2^(AWIDTH-1) and set sticky ovf.
  - S4: when the S3 entry is last, compute requant and drive outputs; o_valid=1 for exactly one cycle.
- Latency: i_valid&i_last at cycle T gives o_valid at T+4.
- Bubbles (i_valid=0): nothing advances into the accumulator; acc and ovf hold. Gaps inside a group are legal.
- i_first&i_last in the same cycle: single-term group; o_acc equals the product.
- Back-to-back groups: last of group A at T and first of group B at T+1 are legal, with no interference.
- Valid without a preceding first: adds to the held accumulator. This is legal (continuation).
- Requant, with s = i_shift latched at last:
  - s=0: r=acc.
  - s>0: r=(acc + 2^(s-1)) >>> s, computed at AWIDTH+1 bits (round-half-up).
  - o_q = clamp(r, -2^(DWIDTH-1), 2^(DWIDTH-1)-1).
  - o_qsat=1 iff clamped.
- Outputs o_acc, o_q, o_ovf, o_qsat hold their last value between o_valid pulses.

Decomposition:
- qsim_pkg holds shared constants:
  - Default DWIDTH/AWIDTH/SWIDTH.
  - Latency constant QMAC_LAT=4.
  - Saturation bound functions/localparams (max/min for a given width).
- Sub-module: the existing qmult is reused unchanged as the S2 product stage.
- Requant/saturation stays inline.

Test Plan:
- Single-term, first&last: (-128)*(-128), shift 0 -> o_valid at T+4, o_acc=16384, o_q=127, o_qsat=1, o_ovf=0.
- Three-term group: 127*127 three times, shift 8 -> o_acc=48387, r=189, o_q=127, o_qsat=1. Repeat with 2*3, (-1)*1, 4*5, shift 0 -> o_acc=25, o_q=25.
- Rounding: single term -3*1, shift 1 -> o_q=-1. Single term 5*1, shift 1 -> o_q=3. Single term -128*1, shift 1 -> o_q=-64, o_qsat=0.
- Accumulator saturation, AWIDTH=16 instance: 127*127 three times -> o_acc=32767, o_ovf=1. The next group, 1*1 single term -> o_acc=1, o_ovf=0.
- Bubbles and back-to-back: group {2*3, gap 3 cycles, 4*4 last}, then group B {1*1 first&last} next cycle -> two pulses one cycle apart, o_acc=22 then 1.
- Reset mid-group: 3 products issued, i_rst pulsed before last -> no o_valid; all outputs 0. The next group {7*7 single} -> o_acc=49.
- Random: 200 random groups with random lengths, gaps, and shifts against a reference model; every o_valid is checked; the bench stops on the first mismatch.

Source files
------------

// File: rtl/qsim_pkg.sv
// Shared constants and saturation-bound helpers for the qsim datapath blocks.
package qsim_pkg;

    localparam int QSIM_DWIDTH = 8;
    localparam int QSIM_AWIDTH = 24;
    localparam int QSIM_SWIDTH = 5;
    localparam int QMAC_LAT    = 4;

    // Largest / smallest two's-complement value representable in w bits.
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/qmult.sv
// Exact signed multiplier; the 2*DWIDTH product holds every operand pair.
module qmult
    import qsim_pkg::*;
#(
    parameter int DWIDTH = QSIM_DWIDTH
) (
    input  logic signed [DWIDTH-1:0]   i_multiplicand,
    input  logic signed [DWIDTH-1:0]   i_multiplier,
    output logic signed [2*DWIDTH-1:0] o_product
);

    localparam int PW = 2 * DWIDTH;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;

    assign a_ext     = PW'(i_multiplicand);
    assign b_ext     = PW'(i_multiplier);
    assign o_product = a_ext * b_ext;

endmodule

// File: rtl/qmac_pipe.sv
// Four-stage signed multiply-accumulate: operand register, product, saturating
// accumulate, then round/shift/saturate requantisation on the group's last term.
module qmac_pipe
    import qsim_pkg::*;
#(
    parameter int DWIDTH = QSIM_DWIDTH,
    parameter int AWIDTH = QSIM_AWIDTH,
    parameter int SWIDTH = QSIM_SWIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_first,
    input  logic              i_last,
    input  logic [DWIDTH-1:0] i_multiplicand,
    input  logic [DWIDTH-1:0] i_multiplier,
    input  logic [SWIDTH-1:0] i_shift,
    output logic              o_valid,
    output logic [AWIDTH-1:0] o_acc,
    output logic [DWIDTH-1:0] o_q,
    output logic              o_ovf,
    output logic              o_qsat
);

    localparam int PW = 2 * DWIDTH;
    localparam logic signed [AWIDTH-1:0] ACC_MAX = AWIDTH'(sat_max(AWIDTH));
    localparam logic signed [AWIDTH-1:0] ACC_MIN = AWIDTH'(sat_min(AWIDTH));
    localparam logic signed [AWIDTH:0]   Q_MAX   = (AWIDTH + 1)'(sat_max(DWIDTH));
    localparam logic signed [AWIDTH:0]   Q_MIN   = (AWIDTH + 1)'(sat_min(DWIDTH));

    logic                     s1_valid, s1_first, s1_last;
    logic [SWIDTH-1:0]        s1_shift;
    logic signed [DWIDTH-1:0] s1_a, s1_b;

    logic                     s2_valid, s2_first, s2_last;
    logic [SWIDTH-1:0]        s2_shift;
    logic signed [PW-1:0]     s2_prod;
    logic signed [PW-1:0]     mult_p;

    logic                     s3_emit;
    logic [SWIDTH-1:0]        s3_shift;
    logic signed [AWIDTH-1:0] acc;
    logic                     ovf;

    logic signed [AWIDTH-1:0] prod_ext, acc_nxt;
    logic signed [AWIDTH:0]   sum;
    logic                     sum_ovf;

    logic signed [AWIDTH:0]   acc_w, rnd, r;
    logic signed [DWIDTH-1:0] q_nxt;
    logic                     qsat_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_shift <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= i_valid;
            s1_first <= i_first;
            s1_last  <= i_last;
            s1_shift <= i_shift;
            s1_a     <= $signed(i_multiplicand);
            s1_b     <= $signed(i_multiplier);
        end
    end

    qmult #(.DWIDTH(DWIDTH)) u_qmult (
        .i_multiplicand (s1_a),
        .i_multiplier   (s1_b),
        .o_product      (mult_p)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_shift <= '0;
            s2_prod  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_shift <= s1_shift;
            s2_prod  <= mult_p;
        end
    end

    // One guard bit on the sum exposes overflow as a disagreement of the top two bits.
    always_comb begin
        prod_ext = AWIDTH'(s2_prod);
        sum      = (AWIDTH + 1)'(acc) + (AWIDTH + 1)'(prod_ext);
        sum_ovf  = sum[AWIDTH] ^ sum[AWIDTH-1];
        acc_nxt  = sum[AWIDTH-1:0];
        if (sum_ovf) begin
            acc_nxt = sum[AWIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc      <= '0;
            ovf      <= 1'b0;
            s3_emit  <= 1'b0;
            s3_shift <= '0;
        end else begin
            s3_emit <= s2_valid & s2_last;
            if (s2_valid) begin
                s3_shift <= s2_shift;
                if (s2_first) begin
                    acc <= prod_ext;
                    ovf <= 1'b0;
                end else begin
                    acc <= acc_nxt;
                    ovf <= ovf | sum_ovf;
                end
            end
        end
    end

    // Shifts of AWIDTH or more always round to zero; short-circuit them so the
    // rounding constant never reaches the guard bit.
    always_comb begin
        acc_w = (AWIDTH + 1)'(acc);
        rnd   = '0;
        r     = acc_w;
        if (s3_shift != '0) begin
            if (int'(s3_shift) >= AWIDTH) begin
                r = '0;
            end else begin
                rnd = (AWIDTH + 1)'(1) <<< (s3_shift - SWIDTH'(1));
                r   = (acc_w + rnd) >>> s3_shift;
            end
        end
        qsat_nxt = 1'b0;
        q_nxt    = DWIDTH'(r);
        if (r > Q_MAX) begin
            q_nxt    = DWIDTH'(Q_MAX);
            qsat_nxt = 1'b1;
        end else if (r < Q_MIN) begin
            q_nxt    = DWIDTH'(Q_MIN);
            qsat_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_acc   <= '0;
            o_q     <= '0;
            o_ovf   <= 1'b0;
            o_qsat  <= 1'b0;
        end else begin
            o_valid <= s3_emit;
            if (s3_emit) begin
                o_acc  <= acc;
                o_q    <= q_nxt;
                o_ovf  <= ovf;
                o_qsat <= qsat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_qmac_pipe.sv
// Directed and randomised checks of qmac_pipe; a second instance with a narrow
// accumulator exercises accumulator saturation.
module tb_qmac_pipe;
    import qsim_pkg::*;

    typedef struct packed {
        logic signed [23:0] acc;
        logic signed [7:0]  q;
        logic               ovf;
        logic               qsat;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, first, last;
    logic [7:0]  a, b;
    logic [4:0]  shift;

    logic        o_valid, o_ovf, o_qsat;
    logic [23:0] o_acc;
    logic [7:0]  o_q;
    logic        n_valid, n_ovf, n_qsat;
    logic [15:0] n_acc;
    logic [7:0]  n_q;

    int   cyc = 0;
    int   t_issue = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    res_t got24[$];
    res_t got16[$];
    int   at24[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    qmac_pipe dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_first(first), .i_last(last),
        .i_multiplicand(a), .i_multiplier(b), .i_shift(shift),
        .o_valid(o_valid), .o_acc(o_acc), .o_q(o_q), .o_ovf(o_ovf), .o_qsat(o_qsat)
    );

    qmac_pipe #(.AWIDTH(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_first(first), .i_last(last),
        .i_multiplicand(a), .i_multiplier(b), .i_shift(shift),
        .o_valid(n_valid), .o_acc(n_acc), .o_q(n_q), .o_ovf(n_ovf), .o_qsat(n_qsat)
    );

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            got24.push_back(res_t'{acc: $signed(o_acc), q: $signed(o_q), ovf: o_ovf, qsat: o_qsat});
            at24.push_back(cyc);
        end
        if (n_valid === 1'b1) begin
            got16.push_back(res_t'{acc: 24'($signed(n_acc)), q: $signed(n_q), ovf: n_ovf, qsat: n_qsat});
        end
    end

    function automatic string fmt(input res_t r);
        return $sformatf("acc=%0d q=%0d ovf=%0d qsat=%0d", r.acc, r.q, r.ovf, r.qsat);
    endfunction

    function automatic res_t mk(input longint acc, input longint q, input bit ovf, input bit qsat);
        return res_t'{acc: 24'(acc), q: 8'(q), ovf: ovf, qsat: qsat};
    endfunction

    task automatic drive(input bit v, input bit f, input bit l, input int av, input int bv, input int s);
        @(negedge clk);
        valid   = v;
        first   = f;
        last    = l;
        a       = 8'(av);
        b       = 8'(bv);
        shift   = 5'(s);
        t_issue = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_results();
        got24.delete();
        got16.delete();
        at24.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b, expected 0", o_valid);
        end
        n_checks++;
        if ({o_acc, o_q, o_ovf, o_qsat} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got acc=%0d q=%0d ovf=%b qsat=%b, expected all 0", o_acc, o_q, o_ovf, o_qsat);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single();
        res_t exp;
        int   t0;
        clear_results();
        drive(1, 1, 1, -128, -128, 0);
        t0 = t_issue;
        idle(7);
        exp = mk(16384, 127, 0, 1);
        n_checks++;
        if (got24.size() != 1 || got24[0] !== exp) begin
            n_fail++;
            $display("FAIL single_term: got %s (pulses=%0d), expected %s", got24.size() > 0 ? fmt(got24[0]) : "none", got24.size(), fmt(exp));
        end
        n_checks++;
        if (at24.size() < 1 || at24[0] - t0 != QMAC_LAT) begin
            n_fail++;
            $display("FAIL single_latency: got %0d, expected %0d", at24.size() > 0 ? at24[0] - t0 : -1, QMAC_LAT);
        end
        n_checks++;
        if (o_valid !== 1'b0 || $signed(o_acc) !== 24'sd16384 || o_qsat !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hold: got valid=%b acc=%0d qsat=%b, expected valid=0 acc=16384 qsat=1", o_valid, $signed(o_acc), o_qsat);
        end
    endtask

    task automatic test_three_term();
        res_t exp0, exp1;
        clear_results();
        drive(1, 1, 0, 127, 127, 0);
        drive(1, 0, 0, 127, 127, 0);
        drive(1, 0, 1, 127, 127, 8);
        drive(1, 1, 0, 2, 3, 0);
        drive(1, 0, 0, -1, 1, 0);
        drive(1, 0, 1, 4, 5, 0);
        idle(7);
        exp0 = mk(48387, 127, 0, 1);
        exp1 = mk(25, 25, 0, 0);
        n_checks++;
        if (got24.size() != 2) begin
            n_fail++;
            $display("FAIL three_term_count: got %0d pulses, expected 2", got24.size());
        end
        n_checks++;
        if (got24.size() < 1 || got24[0] !== exp0) begin
            n_fail++;
            $display("FAIL three_term_sat: got %s, expected %s", got24.size() > 0 ? fmt(got24[0]) : "none", fmt(exp0));
        end
        n_checks++;
        if (got24.size() < 2 || got24[1] !== exp1) begin
            n_fail++;
            $display("FAIL three_term_small: got %s, expected %s", got24.size() > 1 ? fmt(got24[1]) : "none", fmt(exp1));
        end
    endtask

    task automatic test_rounding();
        res_t exp[4];
        clear_results();
        drive(1, 1, 1, -3, 1, 1);
        drive(1, 1, 1, 5, 1, 1);
        drive(1, 1, 1, -128, 1, 1);
        drive(1, 1, 1, -128, -128, 31);
        idle(7);
        exp[0] = mk(-3, -1, 0, 0);
        exp[1] = mk(5, 3, 0, 0);
        exp[2] = mk(-128, -64, 0, 0);
        exp[3] = mk(16384, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got24.size() <= i || got24[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL rounding_%0d: got %s, expected %s", i, got24.size() > i ? fmt(got24[i]) : "none", fmt(exp[i]));
            end
        end
    endtask

    task automatic test_acc_sat();
        res_t exp[3];
        res_t e24;
        clear_results();
        drive(1, 1, 0, 127, 127, 0);
        drive(1, 0, 0, 127, 127, 0);
        drive(1, 0, 1, 127, 127, 0);
        drive(1, 1, 1, 1, 1, 0);
        drive(1, 1, 0, -128, 127, 0);
        drive(1, 0, 0, -128, 127, 0);
        drive(1, 0, 1, -128, 127, 0);
        idle(7);
        exp[0] = mk(32767, 127, 1, 1);
        exp[1] = mk(1, 1, 0, 0);
        exp[2] = mk(-32768, -128, 1, 1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got16.size() <= i || got16[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL acc_sat_%0d: got %s, expected %s", i, got16.size() > i ? fmt(got16[i]) : "none", fmt(exp[i]));
            end
        end
        e24 = mk(-48768, -128, 0, 1);
        n_checks++;
        if (got24.size() < 3 || got24[2] !== e24) begin
            n_fail++;
            $display("FAIL acc_wide_nosat: got %s, expected %s", got24.size() > 2 ? fmt(got24[2]) : "none", fmt(e24));
        end
    endtask

    task automatic test_back_to_back();
        res_t exp0, exp1;
        clear_results();
        drive(1, 1, 0, 2, 3, 0);
        idle(3);
        drive(1, 0, 1, 4, 4, 0);
        drive(1, 1, 1, 1, 1, 0);
        idle(7);
        exp0 = mk(22, 22, 0, 0);
        exp1 = mk(1, 1, 0, 0);
        n_checks++;
        if (at24.size() != 2 || at24[1] - at24[0] != 1) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d pulses, expected 2 pulses one cycle apart", at24.size());
        end
        n_checks++;
        if (got24.size() < 1 || got24[0] !== exp0) begin
            n_fail++;
            $display("FAIL b2b_gap_group: got %s, expected %s", got24.size() > 0 ? fmt(got24[0]) : "none", fmt(exp0));
        end
        n_checks++;
        if (got24.size() < 2 || got24[1] !== exp1) begin
            n_fail++;
            $display("FAIL b2b_second: got %s, expected %s", got24.size() > 1 ? fmt(got24[1]) : "none", fmt(exp1));
        end
    endtask

    task automatic test_reset_mid();
        res_t exp;
        clear_results();
        drive(1, 1, 0, 3, 3, 0);
        drive(1, 0, 0, 3, 3, 0);
        drive(1, 0, 0, 3, 3, 0);
        @(negedge clk);
        valid = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(7);
        n_checks++;
        if (got24.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_pulse: got %0d pulses, expected 0", got24.size());
        end
        n_checks++;
        if ({o_acc, o_q, o_ovf, o_qsat} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got acc=%0d q=%0d ovf=%b qsat=%b, expected all 0", o_acc, o_q, o_ovf, o_qsat);
        end
        drive(1, 1, 1, 7, 7, 0);
        idle(7);
        exp = mk(49, 49, 0, 0);
        n_checks++;
        if (got24.size() != 1 || got24[0] !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_next: got %s, expected %s", got24.size() > 0 ? fmt(got24[0]) : "none", fmt(exp));
        end
    endtask

    task automatic test_continuation();
        res_t exp;
        clear_results();
        drive(1, 0, 1, 2, 2, 3);
        idle(7);
        exp = mk(53, 7, 0, 0);
        n_checks++;
        if (got24.size() != 1 || got24[0] !== exp) begin
            n_fail++;
            $display("FAIL continuation: got %s, expected %s", got24.size() > 0 ? fmt(got24[0]) : "none", fmt(exp));
        end
    endtask

    task automatic test_random();
        res_t   exp_q[$];
        longint acc, r, q;
        bit     ovf, qsat;
        int     len, av, bv, s;
        clear_results();
        for (int g = 0; g < 200; g++) begin
            len = $urandom_range(1, 6);
            acc = 0;
            ovf = 0;
            s   = 0;
            for (int k = 0; k < len; k++) begin
                av = int'($urandom_range(0, 255)) - 128;
                bv = int'($urandom_range(0, 255)) - 128;
                if (k == len - 1) s = $urandom_range(0, 14);
                if (k == 0) begin
                    acc = longint'(av * bv);
                    ovf = 0;
                end else begin
                    acc = acc + longint'(av * bv);
                    if (acc > sat_max(24)) begin acc = sat_max(24); ovf = 1; end
                    if (acc < sat_min(24)) begin acc = sat_min(24); ovf = 1; end
                end
                drive(1, k == 0, k == len - 1, av, bv, s);
                if (k < len - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            r = (s == 0) ? acc : ((acc + (64'sd1 <<< (s - 1))) >>> s);
            q = r;
            qsat = 0;
            if (r > 127)  begin q = 127;  qsat = 1; end
            if (r < -128) begin q = -128; qsat = 1; end
            exp_q.push_back(mk(acc, q, ovf, qsat));
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(7);
        n_checks++;
        if (got24.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d pulses, expected %0d", got24.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got24.size() <= i || got24[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_group_%0d: got %s, expected %s", i, got24.size() > i ? fmt(got24[i]) : "none", fmt(exp_q[i]));
                break;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        first = 1'b0;
        last  = 1'b0;
        a     = '0;
        b     = '0;
        shift = '0;
        test_reset();
        test_single();
        test_three_term();
        test_rounding();
        test_acc_sat();
        test_back_to_back();
        test_reset_mid();
        test_continuation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
